// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers for the EX stage.
// MULT/MULTU/DIV/DIVU run over several cycles on operand magnitudes and apply
// a sign fixup at the end. MTHI/MTLO write HI/LO in a single edge.
// Handshake: a request is taken on any rising edge where start=1, busy=0 and
// flush=0. While busy=1 every start is dropped and the pipeline must hold the
// instruction. done pulses for one cycle when new MULT/DIV results show up on
// hi/lo.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbgState
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [CW-1:0]      count;
    logic               isDiv;
    logic               negRes;     // quotient / product must be negated
    logic               negRem;     // remainder takes the dividend's sign
    logic [WIDTH-1:0]   rawA;       // unmodified dividend for divide-by-zero
    logic [WIDTH-1:0]   workB;      // divisor, or multiplier shifted right
    logic [2*WIDTH-1:0] mcand;      // multiplicand shifted left
    logic [2*WIDTH-1:0] acc;        // product, or {remainder, quotient}

    logic               accept;
    logic               lastIter;
    logic               signA, signB;
    logic [WIDTH-1:0]   magA, magB;
    logic [WIDTH:0]     remShift, diff;
    logic [2*WIDTH-1:0] prodOut;
    logic [WIDTH-1:0]   resHi, resLo;

    assign busy     = (state != IDLE);
    assign dbgState = state;
    assign accept   = (state == IDLE) && start && !flush && !op[2];
    assign lastIter = (count == CW'(WIDTH - 1)) || (FAST_MUL && !isDiv);

    // Operand magnitudes and sign flags; op[0]=0 selects the signed variants.
    always_comb begin
        signA = !op[0] && src_a[WIDTH-1];
        signB = !op[0] && src_b[WIDTH-1];
        magA  = signA ? (~src_a + 1'b1) : src_a;
        magB  = signB ? (~src_b + 1'b1) : src_b;
    end

    // One restoring-division step and the signed result fixup.
    always_comb begin
        remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = remShift - {1'b0, workB};
        prodOut  = negRes ? (~acc + 1'b1) : acc;
        resHi    = prodOut[2*WIDTH-1:WIDTH];
        resLo    = prodOut[WIDTH-1:0];
        if (isDiv) begin
            if (workB == '0) begin
                resHi = rawA;
                resLo = '1;
            end else begin
                resLo = negRes ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
                resHi = negRem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1)
                               : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic; flush returns to IDLE from any busy state.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = CALC;
            CALC: begin
                if (flush)         stateNext = IDLE;
                else if (lastIter) stateNext = FIN;
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: operand capture, iterations, HI/LO writeback and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            count  <= '0;
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            rawA   <= '0;
            workB  <= '0;
            mcand  <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        isDiv  <= op[1];
                        negRes <= signA ^ signB;
                        negRem <= signA;
                        rawA   <= src_a;
                        workB  <= magB;
                        mcand  <= {{WIDTH{1'b0}}, magA};
                        acc    <= op[1] ? {{WIDTH{1'b0}}, magA} : '0;
                        count  <= '0;
                    end else if (start && !flush && op == 3'd4) begin
                        hi <= src_a;
                    end else if (start && !flush && op == 3'd5) begin
                        lo <= src_a;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        count <= count + CW'(1);
                        if (isDiv) begin
                            if (!diff[WIDTH])
                                acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                            else
                                acc <= {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        end else if (FAST_MUL) begin
                            acc <= {{WIDTH{1'b0}}, mcand[WIDTH-1:0]} *
                                   {{WIDTH{1'b0}}, workB};
                        end else begin
                            if (workB[0]) acc <= acc + mcand;
                            mcand <= mcand << 1;
                            workB <= workB >> 1;
                        end
                    end
                end
                FIN: begin
                    if (!flush) begin
                        hi   <= resHi;
                        lo   <= resLo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers, in the EX stage of the pipelined MIPS core.
- Operands come straight from the register-file read ports (rs on src_a, rt on src_b) via the ID/EX latch.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and raises busy so the hazard unit stalls the pipeline.
- Also services MTHI/MTLO; hi/lo feed MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- FAST_MUL, 0, 0 = 32-iteration shift-add multiply; 1 = multiply completes in a single CALC cycle.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved (ignored).
- src_a  input  WIDTH  rs value (dividend / multiplicand / MTHI/MTLO source).
- src_b  input  WIDTH  rt value (divisor / multiplier).
- flush  input  1  abort the in-flight op (exception/branch squash).
- busy  output  1  high while an arithmetic op is in flight; the pipeline stalls on it.
- done  output  1  one-cycle pulse in the first cycle new HI/LO from MULT/DIV are visible.
- hi  output  WIDTH  HI register (registered).
- lo  output  WIDTH  LO register (registered).

Behaviour:
- Reset: sync, active-high, overrides everything. State=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and work registers cleared.
- Reset mid-op discards the op; HI/LO read 0 the cycle after.

State machine (IDLE, CALC, FIN):
- busy = (state != IDLE).
- done is registered and defaults to 0 every cycle.

IDLE:
- On edge T with start=1 and flush=0 and op in 0..3:
  - latch operands; for signed ops latch magnitudes plus sign flags;
  - counter=0; go to CALC.
- op 4 (MTHI) at edge T: hi <= src_a; op 5 (MTLO) at edge T: lo <= src_a.
  - No busy, no done; new value visible at T+1.
- flush=1 in IDLE: start is ignored that cycle (flush wins).

CALC (one iteration per cycle):
- Multiply: shift-add on magnitudes, 64-bit accumulator.
- Divide: restoring, one quotient bit per cycle.
- After iteration 32 (or 1 if FAST_MUL=1 and op is MULT/MULTU), go to FIN.

FIN:
- Apply sign fixup.
- At the FIN edge write HI/LO and set done=1; go to IDLE.
- Latency (DIV, or MULT with FAST_MUL=0): accept edge T; busy high T+1..T+33; HI/LO valid and done=1 at T+34.
- Latency (MULT with FAST_MUL=1): busy high T+1..T+2; done at T+3.

Arithmetic rules:
- MULT/MULTU: {hi,lo} = full 64-bit product. MULT negates the product if operand signs differ.
- DIVU: lo = quotient, hi = remainder.
- DIV: quotient negated if signs differ; remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=src_a as latched (raw dividend); no sign fixup.

Busy-period rules:
- flush=1 while busy: return to IDLE next edge; HI/LO unchanged; no done pulse.
- start while busy: ignored, including MTHI/MTLO. The pipeline holds the instruction and re-presents it after busy falls.
- Operand inputs are don't-care after the accept edge.
- A start in the done cycle (busy=0) is accepted normally (back-to-back ops).

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles; done at T+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFA (-6) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. Repeat with FAST_MUL=1 -> done at T+3, same result.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234. MTHI 0xDEADBEEF then MTLO 0x5 on consecutive cycles -> hi/lo update at T+1 and T+2; busy never set.
- Start DIV, assert flush at cycle T+10 -> busy low at T+11; HI/LO keep prior values; no done pulse. Assert rst at T+5 of another op -> hi=lo=0, busy=0 next cycle.
- Start MULT while busy with a DIV -> ignored; DIV result correct. New start in the done cycle is accepted; busy rises at the next edge.
